// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit for the MIPS datapath.
// Multiply is radix-2 Booth. Divide is restoring division on operand magnitudes,
// followed by one sign-correction cycle. Both take 33 cycles from start to done.
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous active-low reset
//   start     in   request, sampled on the rising edge (accepted in IDLE/DONE)
//   op        in   0 = mult, 1 = div, sampled with start
//   a, b      in   32-bit signed operands (multiplicand/dividend, multiplier/divisor)
//   busy      out  operation in progress
//   done      out  one-cycle pulse, hi/lo valid
//   hi, lo    out  mult: product[63:32]/[31:0]; div: remainder/quotient
//   div_zero  out  divide-by-zero flag (0 unless the option below is enabled)
//
// Build option: define DIV_BY_ZERO_EXC_EN to make a divide by zero finish in one
// cycle through the DZ state and raise div_zero. Without it, a zero divisor runs
// the full sequence and produces lo=32'hFFFFFFFF, hi=a.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
`ifdef DIV_BY_ZERO_EXC_EN
    , ST_DZ = 3'd5
`endif
  } state_t;

  // Two's-complement negation, mod 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  // Magnitude; -2^31 maps to 32'h80000000, which is correct as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? neg32(v) : v;
  endfunction

  state_t      state_r;
  logic        op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  // Upper half: Booth A (mult) or partial remainder R (div). It carries one guard
  // bit so that subtracting a multiplicand of -2^31 cannot overflow.
  logic [32:0] acc_hi_r;
  logic [31:0] acc_lo_r;   // Booth Q (mult) or quotient/dividend shift register (div)
  logic        qm1_r;      // Booth Q-1 bit
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
`ifdef DIV_BY_ZERO_EXC_EN
  logic        div_zero_r;
`endif

  logic [32:0] mcand_s;
  logic [32:0] booth_sum_s;
  logic [31:0] b_mag_s;
  logic [31:0] r_shift_s;
  logic [32:0] trial_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  // Per-iteration datapath for Booth, restoring divide, and final sign correction.
  always_comb begin
    mcand_s = {a_r[31], a_r};
    case ({acc_lo_r[0], qm1_r})
      2'b01:   booth_sum_s = acc_hi_r + mcand_s;
      2'b10:   booth_sum_s = acc_hi_r - mcand_s;
      default: booth_sum_s = acc_hi_r;
    endcase
    b_mag_s   = abs32(b_r);
    r_shift_s = {acc_hi_r[30:0], acc_lo_r[31]};
    trial_s   = {1'b0, r_shift_s} - {1'b0, b_mag_s};
    if (op_r == 1'b0) begin
      fix_hi_s = acc_hi_r[31:0];
      fix_lo_s = acc_lo_r;
    end else if (b_r == 32'd0) begin
      // Zero divisor: only reachable here when the DZ path is not built.
      fix_hi_s = a_r;
      fix_lo_s = 32'hFFFF_FFFF;
    end else begin
      fix_lo_s = (a_r[31] ^ b_r[31]) ? neg32(acc_lo_r) : acc_lo_r;
      fix_hi_s = a_r[31] ? neg32(acc_hi_r[31:0]) : acc_hi_r[31:0];
    end
  end

  // Control FSM plus iteration registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      op_r       <= 1'b0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      acc_hi_r   <= 33'd0;
      acc_lo_r   <= 32'd0;
      qm1_r      <= 1'b0;
      cnt_r      <= 5'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
`ifdef DIV_BY_ZERO_EXC_EN
      div_zero_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            cnt_r    <= 5'd0;
            qm1_r    <= 1'b0;
            acc_hi_r <= 33'd0;
`ifdef DIV_BY_ZERO_EXC_EN
            div_zero_r <= 1'b0;
`endif
            if (op == 1'b0) begin
              acc_lo_r <= b;
              busy_r   <= 1'b1;
              state_r  <= ST_MULT;
            end
`ifdef DIV_BY_ZERO_EXC_EN
            else if (b == 32'd0) begin
              busy_r  <= 1'b0;
              state_r <= ST_DZ;
            end
`endif
            else begin
              acc_lo_r <= abs32(a);
              busy_r   <= 1'b1;
              state_r  <= ST_DIV;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MULT: begin
          // Add/subtract result is shifted right arithmetically in the same cycle.
          acc_hi_r <= {booth_sum_s[32], booth_sum_s[32:1]};
          acc_lo_r <= {booth_sum_s[0], acc_lo_r[31:1]};
          qm1_r    <= acc_lo_r[0];
          cnt_r    <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_MULT;
          end
        end
        ST_DIV: begin
          if (trial_s[32] == 1'b0) begin
            acc_hi_r <= {1'b0, trial_s[31:0]};
            acc_lo_r <= {acc_lo_r[30:0], 1'b1};
          end else begin
            acc_hi_r <= {1'b0, r_shift_s};
            acc_lo_r <= {acc_lo_r[30:0], 1'b0};
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_DONE;
        end
`ifdef DIV_BY_ZERO_EXC_EN
        ST_DZ: begin
          done_r     <= 1'b1;
          div_zero_r <= 1'b1;
          state_r    <= ST_DONE;
        end
`endif
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
`ifdef DIV_BY_ZERO_EXC_EN
  assign div_zero = div_zero_r;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors with literal expectations plus an
// arithmetic reference model checked against every output on every cycle.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int lat;

`ifdef DIV_BY_ZERO_EXC_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain signed arithmetic.
  function automatic logic [63:0] model_result(input logic o, input logic [31:0] x,
                                               input logic [31:0] y);
    longint p;
    int q, r;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  // Reference model: a cycle countdown from acceptance to the result.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_dzpend = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_dzpend <= 1'b0;
      m_hi <= 32'd0; m_lo <= 32'd0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_dzpend) begin
        m_done <= 1'b1; m_dz <= 1'b1; m_dzpend <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (start) begin
        m_dz <= 1'b0;
        {p_hi, p_lo} <= model_result(op, a, b);
        if (op && b == 32'd0 && DZ_EN) begin
          m_dzpend <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_cnt <= 33;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("div_zero", 32'(div_zero), 32'(m_dz));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Pulse start for one cycle; operands are scrambled afterwards.
  task automatic go(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Edges from the one after acceptance up to done; 0 if it never came.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // 7 * -3
    go(1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat);
    check("mul1_lat", 32'(lat), 32'd33);
    check("mul1_hi", hi, 32'hFFFF_FFFF);
    check("mul1_lo", lo, 32'hFFFF_FFEB);

    // -2^31 * -2^31
    go(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    check("mul2_hi", hi, 32'h4000_0000);
    check("mul2_lo", lo, 32'h0000_0000);

    // -7 / 2
    go(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("div1_lat", 32'(lat), 32'd33);
    check("div1_lo", lo, 32'hFFFF_FFFD);
    check("div1_hi", hi, 32'hFFFF_FFFF);

    // 100 / 0
    go(1'b1, 32'd100, 32'd0);
    wait_done(lat);
`ifdef DIV_BY_ZERO_EXC_EN
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_hi", hi, 32'hFFFF_FFFF);
    check("dz_lo", lo, 32'hFFFF_FFFD);
`else
    check("dz_lat", 32'(lat), 32'd33);
    check("dz_flag", 32'(div_zero), 32'd0);
    check("dz_hi", hi, 32'd100);
    check("dz_lo", lo, 32'hFFFF_FFFF);
`endif

    // 7 / -2 : remainder follows the dividend sign
    go(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'd1);
    check("div2_dz", 32'(div_zero), 32'd0);

    // 7 * -3 with a stray start at cycle 5 that must be ignored
    go(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 32'(lat), 32'd28);
    check("ign_hi", hi, 32'hFFFF_FFFF);
    check("ign_lo", lo, 32'hFFFF_FFEB);

    // Reset in the middle of a divide
    go(1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_hi", hi, 32'd0);
    check("mid_lo", lo, 32'd0);
    check("mid_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 9 / 4 after reset
    go(1'b1, 32'd9, 32'd4);
    wait_done(lat);
    check("div3_lat", 32'(lat), 32'd33);
    check("div3_lo", lo, 32'd2);
    check("div3_hi", hi, 32'd1);

    // -2^31 / -1, then a start on the done cycle
    go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    go(1'b0, 32'd123, 32'hFFFF_FE38);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'd33);
    check("b2b_hi", hi, 32'hFFFF_FFFF);
    check("b2b_lo", lo, 32'hFFFF_24E8);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath, sitting downstream of the control unit alongside the ALU. The control FSM pulses `start` with `op`, drives operands from registers A/B, and waits in a hold state until `done`. The unit then writes HI/LO, which `MemToReg` selects for `mfhi`/`mflo`. Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with a final sign-correction step.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `start`  in  1  request; sampled on the rising edge.
- `op`  in  1  0 = mult, 1 = div; sampled with `start`.
- `a`  in  32  multiplicand / dividend, signed.
- `b`  in  32  multiplier / divisor, signed.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO valid.
- `hi`  out  32  mult: product[63:32]; div: remainder.
- `lo`  out  32  mult: product[31:0]; div: quotient.
- `div_zero`  out  1  divide-by-zero flag; driven only when `DIV_BY_ZERO_EXC_EN` is defined, otherwise tied 0.

## Operation
- States:
  - IDLE
  - MULT
  - DIV
  - FIX
  - DONE
  - DZ (exists only with the macro)
- Start acceptance:
  - `start` is accepted only in IDLE or DONE, which allows back-to-back operations.
  - `start` is ignored while in MULT, DIV, FIX or DZ.
  - On accept: latch `a` and `b`, clear the iteration counter, clear `div_zero`, and go to MULT or DIV according to `op`.
- MULT:
  - 65-bit Booth accumulator {A[31:0], Q[31:0], Q-1}.
  - Each cycle, on Q[0]:Q-1: 01 adds the multiplicand to A, 10 subtracts it from A, 00 and 11 make no change.
  - Each cycle then performs an arithmetic shift right by 1.
  - 32 iterations, then FIX.
- DIV:
  - Works on |a| and |b|.
  - Each cycle, shift {R, Q} left; trial R−|b|; if the trial result is non-negative, keep it and set Q[0]=1.
  - 32 iterations, then FIX.
- FIX:
  - mult: hi = A, lo = Q.
  - div: quotient is negated when sign(a)≠sign(b); remainder takes the sign of `a`.
  - Load `hi`/`lo`, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE unless a new `start` is accepted.
- Arithmetic is mod 2^32 per word. −2^31 / −1 gives lo=32'h80000000, hi=0.
- `hi`/`lo` hold their value until the next FIX or DZ write, or reset.

## Timing
- Reset (asynchronous, `reset`=0):
  - state IDLE.
  - `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
  - Internal accumulator and counter cleared.
- Reset mid-operation aborts immediately; no `done` pulse is produced.
- Accept edge k:
  - `busy`=1 from k through k+32.
  - Iteration edges are k+1..k+32; FIX is active in the cycle after edge k+32.
  - Edge k+33: `hi`/`lo` updated, `done`=1, `busy`=0.
  - Edge k+34: `done`=0.
  - Latency from `start` to `done` is 33 cycles for both mult and div.
- Operands need to be valid only at edge k.
- `start` asserted at the same edge `done` is high is accepted: `done` drops and `busy` rises at that edge.
- `busy` and `done` are never high simultaneously.

## Configuration
- `DIV_BY_ZERO_EXC_EN` defined:
  - div accepted with b==0 goes to DZ.
  - Next edge: `done`=1, `div_zero`=1, `hi`/`lo` unchanged, `busy` low throughout; latency 1 cycle.
  - `div_zero` holds until the next accepted `start` or reset. The control unit uses it for the exception path.
- Not defined:
  - b==0 runs the full 33 cycles.
  - FIX forces lo=32'hFFFFFFFF and hi=a.
  - `div_zero` is constant 0.

## Test plan
- mult a=7, b=−3 (32'hFFFFFFFD) → 33 cycles later `done`, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- mult a=b=32'h80000000 → hi=32'h40000000, lo=0; then div a=−7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- div a=100, b=0:
  - with macro: `done` + `div_zero`=1 one cycle after accept, hi/lo unchanged.
  - without macro: `done` at 33 cycles, lo=32'hFFFFFFFF, hi=100, `div_zero`=0.
- `start` re-pulsed at cycle 5 with a=1, b=1 during mult 7×−3 → ignored; result still 7×−3 at cycle 33.
- `reset`=0 at cycle 10 of a div → all outputs 0 immediately, no `done`; new div 9/4 after release → lo=2, hi=1.
- div −2^31 / −1 → lo=32'h80000000, hi=0; back-to-back `start` on the `done` cycle is accepted.
